hilo_md_ctrl: RTL and testbench
===============================

// Module: hilo_md_ctrl
// PURPOSE
//  Multi-cycle controller for MIPS mult/multu/div/divu and owner of the HI/LO registers.
//  Sits beside the EX-stage ALU and accepts a one-hot md_op from the decoder.
//  Sequences a shared iterative shift-add / shift-subtract datapath and raises stallreq
//  to freeze the pipeline until the result lands in HI/LO. Also executes mthi/mtlo.
// PARAMETERS
//  DATA_W  32  operand width; HI/LO are DATA_W each; iteration count = DATA_W
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  flush      in   1       pipeline flush (exception/eret); aborts the operation in flight
//  ex_stall   in   1       EX held by another stall source this cycle
//  md_op      in   6       one-hot {mult, multu, div, divu, mthi, mtlo}; all-zero = none
//  src1       in   DATA_W  rs value (dividend / multiplicand / mthi/mtlo data)
//  src2       in   DATA_W  rt value (divisor / multiplier)
//  stallreq   out  1       request pipeline freeze; combinational from state and md_op
//  hi_o       out  DATA_W  HI register
//  lo_o       out  DATA_W  LO register
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, cnt=0, hi_o=0, lo_o=0, internal regs=0; stallreq=0, busy=0.
//  FSM states: IDLE, RUN, DONE.
//  IDLE, md_op mul/div, flush=0:
//   - stallreq=1 combinationally in the same cycle.
//   - Capture |src1|, |src2| (signed ops) or raw values (unsigned ops).
//   - Record result signs; cnt<=0; go to RUN.
//  IDLE, mthi/mtlo, flush=0: write src1 to HI/LO at this edge; no stall; stay in IDLE.
//  RUN: stallreq=1; one bit per cycle; cnt++.
//   - When cnt==DATA_W-1: apply sign fixup, write HI/LO, go to DONE.
//   - Total stallreq high = DATA_W+1 cycles (issue cycle T through T+DATA_W).
//  DONE: stallreq=0, so the instruction leaves EX.
//   - md_op is ignored, so the held instruction does not restart.
//   - ex_stall=1 keeps the FSM in DONE; ex_stall=0 returns it to IDLE.
//  Arithmetic:
//   - mult/multu: {HI,LO} = 64-bit product; signed result negated when signs differ.
//   - div/divu: LO=quotient, HI=remainder.
//   - Signed div: quotient sign = s1^s2; remainder sign = sign of dividend.
//  Divide by zero: LO=all-ones, HI=dividend as given (src1); same iteration count.
//  Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//  flush in any state:
//   - Next state IDLE; HI/LO not written; stallreq=0 in the flush cycle.
//   - A flush in IDLE also suppresses mthi/mtlo.
//  rst mid-operation: immediate return to reset values.
//  md_op with more than one bit set: not legal; no defined behaviour required.
// STRUCTURE
//  defines.vh:
//   - `MdOpBus 5:0
//   - op index constants MD_MULT=5, MD_MULTU=4, MD_DIV=3, MD_DIVU=2, MD_MTHI=1, MD_MTLO=0
//   - FSM state encodings.
//  Sub-module md_iter_core (~120 lines):
//   - 2*DATA_W shift register, DATA_W+1 adder/subtractor.
//   - mode input (mul/div), load/step controls.
//  hilo_md_ctrl holds the FSM, counter, sign fixup, div-by-zero handling and HI/LO registers.
// TESTING
//  mult 0xFFFFFFFF*0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE;
//   stallreq high exactly 33 cycles, then low for 1 DONE cycle.
//  multu 0xFFFFFFFF*0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE.
//  div 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1;
//   div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  divu 5/0 -> LO=0xFFFFFFFF, HI=5 after 33 stall cycles.
//  div issued, flush at RUN cycle 10 -> stallreq=0 that cycle, HI/LO unchanged;
//   mult on the following cycle completes correctly.
//  mthi 0x12345678 in IDLE -> hi_o=0x12345678 next cycle, stallreq never high;
//   mult reaching DONE with ex_stall=1 for 3 cycles and md_op held -> stays DONE, no restart,
//   HI/LO written once; async rst pulse mid-RUN -> all outputs 0.

Source files
------------

// File: rtl/hilo_md_ctrl_pkg.sv
// hilo_md_ctrl_pkg: md_op bit positions, FSM states and op decode helper
package hilo_md_ctrl_pkg;
    localparam int MD_MULT = 5;
    localparam int MD_MULTU = 4;
    localparam int MD_DIV = 3;
    localparam int MD_DIVU = 2;
    localparam int MD_MTHI = 1;
    localparam int MD_MTLO = 0;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} md_state_t;
    function automatic logic is_md_start(input logic [5:0] op);
        return |op[MD_MULT:MD_DIVU];
    endfunction
endpackage

// File: rtl/hilo_md_ctrl_md_iter_core.sv
// md_iter_core: one-bit-per-step unsigned shift-add multiplier / restoring divider
module md_iter_core #(parameter int DATA_W = 32) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_div,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic [2*DATA_W-1:0]   o_next
);
    logic [2*DATA_W-1:0] r_p;
    logic [DATA_W-1:0]   r_b;
    logic                r_div;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_sh;
    logic [DATA_W-1:0]   w_diff;
    logic                w_ge;
    always_comb begin
        w_sum  = {1'b0, r_p[2*DATA_W-1:DATA_W]} + (r_p[0] ? {1'b0, r_b} : '0);
        w_sh   = {r_p[2*DATA_W-1:DATA_W], r_p[DATA_W-1]};
        w_ge   = w_sh >= {1'b0, r_b};
        w_diff = w_sh[DATA_W-1:0] - r_b;
        o_next = r_div ? (w_ge ? {w_diff, r_p[DATA_W-2:0], 1'b1} : {w_sh[DATA_W-1:0], r_p[DATA_W-2:0], 1'b0})
                       : {w_sum, r_p[DATA_W-1:1]};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p   <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_p   <= {{DATA_W{1'b0}}, i_div ? i_a : i_b};
            r_b   <= i_div ? i_b : i_a;
            r_div <= i_div;
        end else if (i_step) begin
            r_p   <= o_next;
        end
    end
endmodule

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: multi-cycle mult/div sequencer and HI/LO register owner
module hilo_md_ctrl
    import hilo_md_ctrl_pkg::*;
#(parameter int DATA_W = 32) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic [5:0]        md_op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              stallreq,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);
    md_state_t           r_state, w_next;
    logic [CW-1:0]       r_cnt;
    logic                r_neg_q, r_neg_r, r_is_div, r_dbz;
    logic                w_start, w_signed, w_div, w_s1, w_s2, w_load, w_step, w_last;
    logic [DATA_W-1:0]   w_a, w_b, w_rem, w_quot;
    logic [2*DATA_W-1:0] w_core, w_prod;
    always_comb begin
        w_start  = is_md_start(md_op);
        w_signed = md_op[MD_MULT] | md_op[MD_DIV];
        w_div    = md_op[MD_DIV] | md_op[MD_DIVU];
        w_s1     = w_signed & src1[DATA_W-1];
        w_s2     = w_signed & src2[DATA_W-1];
        w_a      = w_s1 ? -src1 : src1;
        w_b      = w_s2 ? -src2 : src2;
        w_load   = r_state == S_IDLE && w_start && !flush;
        w_step   = r_state == S_RUN && !flush;
        w_last   = w_step && r_cnt == CW'(DATA_W - 1);
        w_prod   = r_neg_q ? -w_core : w_core;
        w_rem    = r_neg_r ? -w_core[2*DATA_W-1:DATA_W] : w_core[2*DATA_W-1:DATA_W];
        w_quot   = r_dbz ? '1 : r_neg_q ? -w_core[DATA_W-1:0] : w_core[DATA_W-1:0];
    end
    md_iter_core #(.DATA_W(DATA_W)) u_core (
        .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step), .i_div(w_div),
        .i_a(w_a), .i_b(w_b), .o_next(w_core)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = flush ? S_IDLE
               : r_state == S_IDLE ? (w_start ? S_RUN : S_IDLE)
               : r_state == S_RUN ? (r_cnt == CW'(DATA_W - 1) ? S_DONE : S_RUN)
               : ex_stall ? S_DONE : S_IDLE;
    end
    always_comb begin
        stallreq = !rst && !flush && (r_state == S_RUN || (r_state == S_IDLE && w_start));
        busy     = r_state != S_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_dbz    <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            if (w_load) begin
                r_cnt    <= '0;
                r_neg_q  <= w_s1 ^ w_s2;
                r_neg_r  <= w_s1;
                r_is_div <= w_div;
                r_dbz    <= w_div && src2 == '0;
            end
            if (w_step) r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                hi_o <= r_is_div ? w_rem : w_prod[2*DATA_W-1:DATA_W];
                lo_o <= r_is_div ? w_quot : w_prod[DATA_W-1:0];
            end
            if (r_state == S_IDLE && !flush && md_op[MD_MTHI]) hi_o <= src1;
            if (r_state == S_IDLE && !flush && md_op[MD_MTLO]) lo_o <= src1;
        end
    end
endmodule

// File: tb/tb_hilo_md_ctrl.sv
// tb_hilo_md_ctrl: vector table, random ops vs arithmetic model, and flush/stall/reset sequences
module tb_hilo_md_ctrl;
    localparam logic [5:0] OP_MULT = 6'b100000;
    localparam logic [5:0] OP_MULTU = 6'b010000;
    localparam logic [5:0] OP_DIV = 6'b001000;
    localparam logic [5:0] OP_DIVU = 6'b000100;
    localparam logic [5:0] OP_MTHI = 6'b000010;
    localparam logic [5:0] OP_MTLO = 6'b000001;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ex_stall = 1'b0;
    logic [5:0] md_op = '0;
    logic [31:0] src1 = '0, src2 = '0;
    logic stallreq, busy;
    logic [31:0] hi_o, lo_o;
    int checks = 0, errors = 0;
    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t vecs[7];
    always #5 clk = ~clk;
    hilo_md_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall), .md_op(md_op),
        .src1(src1), .src2(src2), .stallreq(stallreq), .hi_o(hi_o), .lo_o(lo_o), .busy(busy)
    );
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        sa = $signed(a);
        sb = $signed(b);
        qa = $signed(a);
        qb = $signed(b);
        if (op == OP_MULT) return sa * sb;
        if (op == OP_MULTU) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (op == OP_DIV) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            return {32'(qa % qb), 32'(qa / qb)};
        end
        return {a % b, a / b};
    endfunction
    task automatic run_op(input string n, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        @(negedge clk);
        md_op = op;
        src1 = a;
        src2 = b;
        #1;
        cyc = 0;
        while (stallreq && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk({n, " stall_cycles"}, 64'(cyc), 64'd33);
        chk({n, " busy_done"}, 64'(busy), 64'd1);
        chk({n, " hi"}, 64'(hi_o), 64'(ehi));
        chk({n, " lo"}, 64'(lo_o), 64'(elo));
        md_op = '0;
        @(negedge clk);
        #1;
        chk({n, " idle_after"}, 64'({busy, stallreq}), 64'd0);
    endtask
    initial begin
        logic [63:0] e;
        logic [31:0] ph, pl, a, b;
        logic [5:0] op;
        int cyc;
        vecs[0] = '{OP_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE};
        vecs[2] = '{OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU, 32'h7, 32'h2, 32'h1, 32'h3};
        vecs[4] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        vecs[5] = '{OP_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF};
        vecs[6] = '{OP_DIV, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF};
        #1;
        chk("reset_outputs", {30'b0, stallreq, busy, hi_o}, 64'd0);
        chk("reset_lo", 64'(lo_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        @(negedge clk);
        md_op = OP_MTHI;
        src1 = 32'h12345678;
        #1;
        chk("mthi stallreq", 64'(stallreq), 64'd0);
        @(negedge clk);
        md_op = OP_MTLO;
        src1 = 32'h9ABCDEF0;
        #1;
        chk("mthi hi", 64'(hi_o), 64'h12345678);
        chk("mtlo stallreq", 64'(stallreq), 64'd0);
        @(negedge clk);
        flush = 1'b1;
        md_op = OP_MTLO;
        src1 = 32'hDEADBEEF;
        #1;
        chk("mtlo lo", 64'(lo_o), 64'h9ABCDEF0);
        @(negedge clk);
        flush = 1'b0;
        md_op = '0;
        #1;
        chk("flushed mtlo", 64'(lo_o), 64'h9ABCDEF0);
        ph = hi_o;
        pl = lo_o;
        @(negedge clk);
        md_op = OP_DIV;
        src1 = 32'd100;
        src2 = 32'd7;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush stallreq", 64'(stallreq), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        md_op = '0;
        #1;
        chk("flush idle", 64'(busy), 64'd0);
        chk("flush hilo", {hi_o, lo_o}, {ph, pl});
        run_op("post_flush mult", OP_MULT, 32'd12345, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFCF_C700);
        @(negedge clk);
        md_op = OP_MULT;
        src1 = 32'd3;
        src2 = 32'hFFFFFFFB;
        #1;
        cyc = 0;
        while (stallreq && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk("exstall stall_cycles", 64'(cyc), 64'd33);
        ex_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("exstall hold%0d", k), {busy, stallreq}, 64'b10);
            chk($sformatf("exstall hilo%0d", k), {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
        end
        ex_stall = 1'b0;
        md_op = '0;
        @(negedge clk);
        #1;
        chk("exstall release", 64'({busy, stallreq}), 64'd0);
        for (int r = 0; r < 40; r++) begin
            op = 6'b000100 << $urandom_range(0, 3);
            a = $urandom_range(0, 4) == 0 ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            e = model(op, a, b);
            run_op($sformatf("rand%0d op%b", r, op), op, a, b, e[63:32], e[31:0]);
        end
        @(negedge clk);
        md_op = OP_MULTU;
        src1 = 32'hFFFF0000;
        src2 = 32'h10;
        repeat (5) @(negedge clk);
        #1;
        chk("rst pre stall", 64'(stallreq), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst async ctl", 64'({busy, stallreq}), 64'd0);
        chk("rst async hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        md_op = '0;
        #1;
        chk("rst after", {30'b0, busy, stallreq, lo_o}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
